// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath/pointer widths common to the register file
// and writeback stage, plus the writeback FSM state type.
package cpu_pkg;

    localparam int CPU_W = 8;
    localparam int CPU_D = 5;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of execute, data-memory, register-file write and hazard signals
// around the writeback stage; master is the stage, slave is its environment.
interface wb_stage_if
    import cpu_pkg::*;
#(
    parameter int W = CPU_W,
    parameter int D = CPU_D
);
    logic         ex_valid;
    logic         ex_ready;
    logic         ex_is_load;
    logic [D-1:0] ex_waddr;
    logic [W-1:0] ex_result;

    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;

    logic         write_en;
    logic [D-1:0] waddr;
    logic [W-1:0] data_in;

    logic [D-1:0] raddrA;
    logic [D-1:0] raddrB;
    logic         hazard;
    logic         err;

    modport master (
        input  ex_valid, ex_is_load, ex_waddr, ex_result,
        input  mem_rvalid, mem_rdata, raddrA, raddrB,
        output ex_ready, mem_req, mem_addr, write_en, waddr, data_in,
        output hazard, err
    );

    modport slave (
        output ex_valid, ex_is_load, ex_waddr, ex_result,
        output mem_rvalid, mem_rdata, raddrA, raddrB,
        input  ex_ready, mem_req, mem_addr, write_en, waddr, data_in,
        input  hazard, err
    );
endinterface

// File: rtl/wb_hazard.sv
// Read-after-write hazard detector for two read pointers against a pending
// load destination and the in-flight register-file write; r0 never hazards.
module wb_hazard
    import cpu_pkg::*;
#(
    parameter int D = CPU_D
) (
    input  logic [D-1:0] i_raddrA,
    input  logic [D-1:0] i_raddrB,
    input  logic         i_pendValid,
    input  logic [D-1:0] i_pendAddr,
    input  logic         i_wrValid,
    input  logic [D-1:0] i_wrAddr,
    output logic         o_hazard
);

    logic w_hitA;
    logic w_hitB;

    always_comb begin
        w_hitA = (i_raddrA != '0) &&
                 ((i_pendValid && (i_raddrA == i_pendAddr)) ||
                  (i_wrValid   && (i_raddrA == i_wrAddr)));
        w_hitB = (i_raddrB != '0) &&
                 ((i_pendValid && (i_raddrB == i_pendAddr)) ||
                  (i_wrValid   && (i_raddrB == i_wrAddr)));
        o_hazard = w_hitA || w_hitB;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle, sequences loads against
// variable-latency memory with a watchdog, and flags RAW hazards for decode.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int W       = CPU_W,
    parameter int D       = CPU_D,
    parameter int TIMEOUT = 15
) (
    input  logic      i_clk,
    input  logic      i_rst,
    wb_stage_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wb_state_t    r_state,  w_state;
    logic [CW-1:0] r_count, w_count;
    logic [D-1:0] r_dest,   w_dest;
    logic         r_wen,    w_wen;
    logic [D-1:0] r_waddr,  w_waddr;
    logic [W-1:0] r_wdata,  w_wdata;
    logic         r_mreq,   w_mreq;
    logic [W-1:0] r_maddr,  w_maddr;
    logic         r_err,    w_err;
    logic         w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_dest  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_mreq  <= 1'b0;
            r_maddr <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_dest  <= w_dest;
            r_wen   <= w_wen;
            r_waddr <= w_waddr;
            r_wdata <= w_wdata;
            r_mreq  <= w_mreq;
            r_maddr <= w_maddr;
            r_err   <= w_err;
        end
    end

    // Writes to r0 are suppressed but the op still retires and frees the stage.
    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_dest   = r_dest;
        w_wen    = 1'b0;
        w_waddr  = r_waddr;
        w_wdata  = r_wdata;
        w_mreq   = 1'b0;
        w_maddr  = r_maddr;
        w_err    = r_err;
        w_accept = bus.ex_valid && (r_state == IDLE);

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.ex_is_load) begin
                        w_state = LOAD_WAIT;
                        w_mreq  = 1'b1;
                        w_maddr = bus.ex_result;
                        w_dest  = bus.ex_waddr;
                        w_count = '0;
                    end else if (bus.ex_waddr != '0) begin
                        w_wen   = 1'b1;
                        w_waddr = bus.ex_waddr;
                        w_wdata = bus.ex_result;
                    end
                end
            end
            LOAD_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_state = IDLE;
                    w_count = '0;
                    if (r_dest != '0) begin
                        w_wen   = 1'b1;
                        w_waddr = r_dest;
                        w_wdata = bus.mem_rdata;
                    end
                end else if (r_count == CW'(TIMEOUT - 1)) begin
                    w_state = IDLE;
                    w_count = '0;
                    w_err   = 1'b1;
                end else begin
                    w_count = r_count + CW'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.ex_ready = (r_state == IDLE);
    assign bus.mem_req  = r_mreq;
    assign bus.mem_addr = r_maddr;
    assign bus.write_en = r_wen;
    assign bus.waddr    = r_waddr;
    assign bus.data_in  = r_wdata;
    assign bus.err      = r_err;

    wb_hazard #(.D(D)) u_hazard (
        .i_raddrA    (bus.raddrA),
        .i_raddrB    (bus.raddrB),
        .i_pendValid (r_state == LOAD_WAIT),
        .i_pendAddr  (r_dest),
        .i_wrValid   (r_wen),
        .i_wrAddr    (r_waddr),
        .o_hazard    (bus.hazard)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes and memory requests go to
// scoreboard queues that a negedge monitor drains and compares.
module tb_wb_stage;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    wr_t  writeQ[$];
    logic [7:0] memQ[$];

    wb_stage_if #(.W(8), .D(5)) bus ();

    wb_stage #(.W(8), .D(5), .TIMEOUT(15)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic isLoad,
                                 input logic [4:0] waddr, input logic [7:0] result);
        bus.ex_valid   = valid;
        bus.ex_is_load = isLoad;
        bus.ex_waddr   = waddr;
        bus.ex_result  = result;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write strobe and memory request must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_en) begin
                if (writeQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got waddr=%0d data=%0h, expected none",
                             bus.waddr, bus.data_in);
                end else begin
                    wr_t exp;
                    exp = writeQ.pop_front();
                    checkOutput("writeAddr", 32'(bus.waddr), 32'(exp.addr));
                    checkOutput("writeData", 32'(bus.data_in), 32'(exp.data));
                end
            end
            if (bus.mem_req) begin
                if (memQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedMemReq: got addr=%0h, expected none", bus.mem_addr);
                end else begin
                    logic [7:0] expAddr;
                    expAddr = memQ.pop_front();
                    checkOutput("memAddr", 32'(bus.mem_addr), 32'(expAddr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
        bus.raddrA     = 5'd0;
        bus.raddrB     = 5'd0;
        #1;
        checkOutput("rstWriteEn", 32'(bus.write_en), 32'd0);
        checkOutput("rstMemReq",  32'(bus.mem_req),  32'd0);
        checkOutput("rstErr",     32'(bus.err),      32'd0);
        checkOutput("rstReady",   32'(bus.ex_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ALU stream: two back-to-back retirements
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h2A);
        writeQ.push_back('{addr: 5'd3, data: 8'h2A});
        tick();
        checkOutput("aluReady1", 32'(bus.ex_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd4, 8'h15);
        writeQ.push_back('{addr: 5'd4, data: 8'h15});
        tick();
        checkOutput("aluReady2", 32'(bus.ex_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        tick();
        tick();

        // Load with latency 3 and an ALU op held behind it
        bus.raddrA = 5'd5;
        applyStimulus(1'b1, 1'b1, 5'd5, 8'h40);
        memQ.push_back(8'h40);
        writeQ.push_back('{addr: 5'd5, data: 8'h99});
        tick();
        applyStimulus(1'b1, 1'b0, 5'd6, 8'h11);
        writeQ.push_back('{addr: 5'd6, data: 8'h11});
        for (int i = 0; i < 3; i++) begin
            checkOutput("loadWaitReady",  32'(bus.ex_ready), 32'd0);
            checkOutput("loadWaitHazard", 32'(bus.hazard),   32'd1);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h99;
        checkOutput("loadRvalidHazard", 32'(bus.hazard), 32'd1);
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("loadWriteHazard", 32'(bus.hazard),   32'd1);
        checkOutput("loadWriteReady",  32'(bus.ex_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("heldOpHazardClear", 32'(bus.hazard), 32'd0);
        tick();
        bus.raddrA = 5'd0;

        // Zero-latency load, then a load to r0
        applyStimulus(1'b1, 1'b1, 5'd9, 8'h50);
        memQ.push_back(8'h50);
        writeQ.push_back('{addr: 5'd9, data: 8'h77});
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h77;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("zeroLatReady", 32'(bus.ex_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd0, 8'h60);
        memQ.push_back(8'h60);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("r0LoadReady",  32'(bus.ex_ready), 32'd0);
        checkOutput("r0LoadHazard", 32'(bus.hazard),   32'd0);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hAB;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("r0RetireReady",  32'(bus.ex_ready), 32'd1);
        checkOutput("r0RetireHazard", 32'(bus.hazard),   32'd0);
        tick();

        // Timeout: no rvalid for 15 LOAD_WAIT cycles
        applyStimulus(1'b1, 1'b1, 5'd10, 8'h70);
        memQ.push_back(8'h70);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        for (int i = 1; i < 15; i++) begin
            checkOutput("toWaitErr",   32'(bus.err),      32'd0);
            checkOutput("toWaitReady", 32'(bus.ex_ready), 32'd0);
            tick();
        end
        checkOutput("toLastErr",   32'(bus.err),      32'd0);
        checkOutput("toLastReady", 32'(bus.ex_ready), 32'd0);
        tick();
        checkOutput("toErr",   32'(bus.err),      32'd1);
        checkOutput("toReady", 32'(bus.ex_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hEE;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        checkOutput("toErrSticky", 32'(bus.err), 32'd1);

        // Asynchronous reset in the middle of LOAD_WAIT
        applyStimulus(1'b1, 1'b1, 5'd11, 8'h80);
        memQ.push_back(8'h80);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstReady",   32'(bus.ex_ready), 32'd1);
        checkOutput("asyncRstErr",     32'(bus.err),      32'd0);
        checkOutput("asyncRstMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("asyncRstWaddr",   32'(bus.waddr),    32'd0);
        checkOutput("asyncRstData",    32'(bus.data_in),  32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h5A;
        tick();
        rst = 1'b0;
        tick();
        bus.mem_rvalid = 1'b0;
        checkOutput("postRstReady", 32'(bus.ex_ready), 32'd1);
        checkOutput("postRstWen",   32'(bus.write_en), 32'd0);
        tick();

        // Hazard on the write cycle only
        bus.raddrB = 5'd7;
        applyStimulus(1'b1, 1'b0, 5'd7, 8'h33);
        writeQ.push_back('{addr: 5'd7, data: 8'h33});
        checkOutput("preWriteHazard", 32'(bus.hazard), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("writeCycleHazard", 32'(bus.hazard), 32'd1);
        bus.raddrB = 5'd6;
        #1;
        checkOutput("otherPtrHazard", 32'(bus.hazard), 32'd0);
        bus.raddrB = 5'd7;
        tick();
        checkOutput("afterWriteHazard", 32'(bus.hazard), 32'd0);
        tick();
        tick();

        checkOutput("writeQueueDrained", 32'(writeQ.size()), 32'd0);
        checkOutput("memQueueDrained",   32'(memQ.size()),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
